// File: rtl/multdiv_seq.sv
// Sequencer for the multicycle Booth-mult / restoring-div engine: latches operands, times the engine, captures HI/LO.
// Optional MULTDIV_ZERO_SHORTCUT_EN: mult with a zero operand bypasses the engine and returns 0 after 2 edges.
module multdiv_seq #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WData,
  input  logic [31:0] Eng_Hi,
  input  logic [31:0] Eng_Lo,
  output logic        Eng_Reset,
  output logic        Eng_Cntrl,
  output logic [31:0] Eng_A,
  output logic [31:0] Eng_B,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] last_count;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   eng_a_q, eng_a_d, eng_b_q, eng_b_d;
  logic          cntrl_q, cntrl_d;
  logic          done_q, done_d, divzero_q, divzero_d;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
  logic          zero_q, zero_d;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      eng_a_q   <= '0;
      eng_b_q   <= '0;
      cntrl_q   <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      eng_a_q   <= eng_a_d;
      eng_b_q   <= eng_b_d;
      cntrl_q   <= cntrl_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

`ifdef MULTDIV_ZERO_SHORTCUT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    eng_a_d    = eng_a_q;
    eng_b_d    = eng_b_q;
    cntrl_d    = cntrl_q;
    done_d     = 1'b0;
    divzero_d  = 1'b0;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
    zero_d     = zero_q;
`endif
    last_count = cntrl_q ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

    case (state_q)
      IDLE: begin
        if (HiWrite) hi_d = WData;
        if (LoWrite) lo_d = WData;
        if (Start) begin
          cntrl_d = Op;
          eng_a_d = OpA;
          eng_b_d = OpB;
          state_d = CLEAR;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
          zero_d  = 1'b0;
          if (!Op && (OpA == '0 || OpB == '0)) begin
            zero_d  = 1'b1;
            state_d = CAPTURE;
          end
`endif
        end
      end
      CLEAR: begin
        // Engine has sampled operands under reset; reject divide-by-zero before it runs.
        if (cntrl_q && eng_b_q == '0) begin
          divzero_d = 1'b1;
          state_d   = IDLE;
        end else begin
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        count_d = count_q + 1'b1;
        if (count_q == last_count) state_d = CAPTURE;
      end
      CAPTURE: begin
        hi_d    = Eng_Hi;
        lo_d    = Eng_Lo;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
        if (zero_q) begin
          hi_d = '0;
          lo_d = '0;
        end
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Eng_Reset = (state_q == IDLE) || (state_q == CLEAR);
  assign Eng_Cntrl = cntrl_q;
  assign Eng_A     = eng_a_q;
  assign Eng_B     = eng_b_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivZero   = divzero_q;
  assign HiOut     = hi_q;
  assign LoOut     = lo_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq with a behavioural signed mult/div engine that
// only presents a valid result 33 clocks after its reset is released.
module tb_multdiv_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start, Op, HiWrite, LoWrite;
  logic [31:0] OpA, OpB, WData;
  logic [31:0] Eng_Hi, Eng_Lo;
  logic        Eng_Reset, Eng_Cntrl, Busy, Done, DivZero;
  logic [31:0] Eng_A, Eng_B, HiOut, LoOut;

  int checks = 0;
  int errors = 0;

  multdiv_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WData(WData),
    .Eng_Hi(Eng_Hi), .Eng_Lo(Eng_Lo), .Eng_Reset(Eng_Reset), .Eng_Cntrl(Eng_Cntrl),
    .Eng_A(Eng_A), .Eng_B(Eng_B), .Busy(Busy), .Done(Done), .DivZero(DivZero),
    .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  // Engine model: operands sampled while in reset, result valid once 33 clocks have elapsed.
  logic [31:0] m_a, m_b;
  logic        m_op;
  int          m_cnt;
  logic [63:0] m_prod;

  always @(posedge Clk) begin
    if (Eng_Reset) begin
      m_a   <= Eng_A;
      m_b   <= Eng_B;
      m_op  <= Eng_Cntrl;
      m_cnt <= 0;
    end else if (m_cnt < 1000) begin
      m_cnt <= m_cnt + 1;
    end
  end

  always_comb begin
    Eng_Hi = 32'hDEAD_BEEF;
    Eng_Lo = 32'hDEAD_BEEF;
    m_prod = 64'(longint'($signed(m_a)) * longint'($signed(m_b)));
    if (m_cnt >= 33) begin
      if (!m_op) begin
        Eng_Hi = m_prod[63:32];
        Eng_Lo = m_prod[31:0];
      end else if (m_b != 0) begin
        Eng_Lo = 32'($signed(m_a) / $signed(m_b));
        Eng_Hi = 32'($signed(m_a) % $signed(m_b));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and watches 60 edges. lat/dz_lat = edge (Start edge = 0) at
  // which Done/DivZero is first sampled high, 0 if never.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int done_cnt, output int dz_lat, output bit stable);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clk); #1;
    Start = 1'b0; Op = ~op; OpA = ~a; OpB = ~b;
    lat = 0; done_cnt = 0; dz_lat = 0; stable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (Eng_A !== a || Eng_B !== b || Eng_Cntrl !== op) stable = 1'b0;
      if (Done === 1'b1) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end
      if (DivZero === 1'b1 && dz_lat == 0) dz_lat = k;
      @(posedge Clk); #1;
    end
  endtask

  int lat, done_cnt, dz_lat;
  bit stable;

  initial begin
    Reset = 1'b0; Start = 1'b0; Op = 1'b0; OpA = '0; OpB = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WData = '0;
    #3;
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_divzero", DivZero, 1'b0);
    check("rst_eng_reset", Eng_Reset, 1'b1);
    check("rst_hi", HiOut, 32'h0);
    check("rst_lo", LoOut, 32'h0);
    check("rst_eng_a", Eng_A, 32'h0);
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;

    // mult 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, done_cnt, dz_lat, stable);
    check("mult_latency", lat, 36);
    check("mult_done_pulses", done_cnt, 1);
    check("mult_hi", HiOut, 32'hFFFF_FFFF);
    check("mult_lo", LoOut, 32'hFFFF_FFEB);
    check("mult_operands_stable", stable, 1'b1);

    // div 100 / 7 = 14 rem 2
    run_op(1'b1, 32'd100, 32'd7, lat, done_cnt, dz_lat, stable);
    check("div_latency", lat, 36);
    check("div_done_pulses", done_cnt, 1);
    check("div_lo", LoOut, 32'd14);
    check("div_hi", HiOut, 32'd2);
    check("div_operands_stable", stable, 1'b1);

    // divide by zero: rejected, HI/LO keep 2/14
    run_op(1'b1, 32'd50, 32'd0, lat, done_cnt, dz_lat, stable);
    check("dz_latency", dz_lat, 2);
    check("dz_no_done", done_cnt, 0);
    check("dz_hi_kept", HiOut, 32'd2);
    check("dz_lo_kept", LoOut, 32'd14);

    // mult 2*3 with a Start+HiWrite pulse injected mid-RUN
    Start = 1'b1; Op = 1'b0; OpA = 32'd2; OpB = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0; lat = 0; dz_lat = 0;
    for (int k = 1; k <= 60; k++) begin
      Start = (k == 6); HiWrite = (k == 6); Op = (k == 6);
      OpA = 32'd9; OpB = 32'd0; WData = 32'h0000_AAAA;
      if (Done === 1'b1 && lat == 0) lat = k;
      if (DivZero === 1'b1 && dz_lat == 0) dz_lat = k;
      @(posedge Clk); #1;
    end
    Start = 1'b0; HiWrite = 1'b0; Op = 1'b0;
    check("busy_ignore_latency", lat, 36);
    check("busy_ignore_no_divzero", dz_lat, 0);
    check("busy_ignore_hi", HiOut, 32'h0);
    check("busy_ignore_lo", LoOut, 32'd6);

    // mthi + mtlo together in IDLE
    HiWrite = 1'b1; LoWrite = 1'b1; WData = 32'h0000_1234;
    @(posedge Clk); #1;
    HiWrite = 1'b0; LoWrite = 1'b0;
    check("mthi_idle", HiOut, 32'h0000_1234);
    check("mtlo_idle", LoOut, 32'h0000_1234);

    // mult with zero operand
    run_op(1'b0, 32'd0, 32'd5, lat, done_cnt, dz_lat, stable);
`ifdef MULTDIV_ZERO_SHORTCUT_EN
    check("zero_mult_latency", lat, 2);
`else
    check("zero_mult_latency", lat, 36);
`endif
    check("zero_mult_hi", HiOut, 32'h0);
    check("zero_mult_lo", LoOut, 32'h0);

    // load HI/LO, then async reset mid-RUN
    HiWrite = 1'b1; LoWrite = 1'b1; WData = 32'h0000_5555;
    @(posedge Clk); #1;
    HiWrite = 1'b0; LoWrite = 1'b0;
    Start = 1'b1; Op = 1'b0; OpA = 32'd7; OpB = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("midrun_rst_busy", Busy, 1'b0);
    check("midrun_rst_eng_reset", Eng_Reset, 1'b1);
    check("midrun_rst_hi", HiOut, 32'h0);
    check("midrun_rst_lo", LoOut, 32'h0);
    check("midrun_rst_eng_a", Eng_A, 32'h0);
    @(negedge Clk); Reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (Done === 1'b1 || Busy === 1'b1) lat = k;
      @(posedge Clk); #1;
    end
    check("midrun_rst_abandoned", lat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
